mult_shift_add: RTL and testbench
=================================

// Module: mult_shift_add
// PURPOSE
//   Sequential shift-and-add unsigned multiplier core instantiated under the memory-mapped
//   multiplier peripheral. The peripheral's A/B/init registers drive op_A/op_B/init.
//   result/done are read back by the CPU over the peripheral bus.
//   One partial product per iteration; early exit once remaining multiplier bits are zero.
// PARAMETERS
//   WIDTH   16   operand width in bits; result is 2*WIDTH bits
// PORTS
//   clk     in   1          system clock, all state on rising edge
//   reset   in   1          asynchronous, active-low reset (0 = reset asserted)
//   init    in   1          start request, level from CPU register; a rising edge starts an operation
//   op_A    in   WIDTH      multiplicand, unsigned, sampled in LOAD
//   op_B    in   WIDTH      multiplier, unsigned, sampled in LOAD
//   result  out  2*WIDTH    product of last completed operation, held until next DONE
//   done    out  1          sticky completion flag
//   busy    out  1          1 in any state other than IDLE
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, result=0, done=0, busy=0, acc/a_sh/b_sh=0, init_q=0.
//   init_q <= init every cycle. start = init & ~init_q. Holding init high does not retrigger.
//   FSM, one state executed per clock edge:
//     IDLE  : if start -> LOAD. Otherwise stay. done and result hold.
//     LOAD  : acc<=0; a_sh<={WIDTH'b0,op_A}; b_sh<=op_B; done<=0 -> CHECK
//     CHECK : b_sh==0 -> DONE; else b_sh[0] ? ADD : SHIFT
//     ADD   : acc<=acc+a_sh (2*WIDTH bits, cannot overflow) -> SHIFT
//     SHIFT : a_sh<=a_sh<<1; b_sh<=b_sh>>1 -> CHECK
//     DONE  : result<=acc; done<=1 -> IDLE
//   Latency: let k = edge where IDLE sees start.
//     m = position of MSB set in op_B + 1, and p = popcount(op_B).
//     done=1 and result valid after edge k+3+2m+p.
//     op_B=0 gives k+3. Worst case for WIDTH=16 (op_B=FFFF) is k+51.
//   op_A/op_B are sampled only in LOAD. Later changes do not affect the running operation.
//   A start while busy is ignored, with no restart and no queueing.
//     init_q still tracks, so an edge that occurs while busy is lost.
//   done falls only in LOAD. From LOAD until DONE, result keeps the previous product.
//   Simultaneous init rise and DONE: the operation completes normally. The edge is consumed
//     while busy and is ignored.
//   Reset mid-operation: immediate async return to reset values. The partial product is discarded.
//   busy rises on the edge entering LOAD and falls on the edge leaving DONE.
// TESTING
//   1. Reset, then A=3, B=5, raise init -> done=1 and result=32'h0000000F exactly 11 edges after start.
//   2. A=FFFF, B=FFFF, init 0->1 -> result=32'hFFFE0001, done after 51 edges, busy high throughout.
//   3. A=1234, B=0 -> result=0, done after 3 edges.
//      Then A=0, B=FFFF -> result=0, done after 51 edges.
//   4. Hold init=1 after a completion -> no restart, done stays 1.
//      Drop init, raise again with A=7, B=6 -> done falls in LOAD, result=42 (0x2A).
//   5. During a busy op (A=FFFF, B=FFFF), toggle init 1->0->1 and change op_A/op_B
//      -> result=32'hFFFE0001, and no second operation runs afterwards.
//   6. Assert reset=0 mid-op (edge 20 of FFFF x FFFF) -> result=0, done=0, busy=0 immediately.
//      After release, a new start with A=2, B=3 -> result=6.

Source files
------------

// File: rtl/mult_shift_add_if.sv
// Operand/result bundle between the multiplier peripheral registers and the
// shift-and-add core. The peripheral side drives the operands and the start level.
interface mult_shift_add_if #(
  parameter int WIDTH = 16
);
  logic                 init;
  logic [WIDTH-1:0]     op_A;
  logic [WIDTH-1:0]     op_B;
  logic [2*WIDTH-1:0]   result;
  logic                 done;
  logic                 busy;

  modport master (
    output init, op_A, op_B,
    input  result, done, busy
  );

  modport slave (
    input  init, op_A, op_B,
    output result, done, busy
  );
endinterface

// File: rtl/mult_shift_add.sv
// Sequential shift-and-add unsigned multiplier. One partial product is added per
// set multiplier bit; iteration stops as soon as the remaining multiplier bits
// are all zero, so latency depends on the highest set bit of op_B.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a rising edge on init; result/done hold
//   LOAD  | capture operands, clear accumulator, drop done
//   CHECK | finish if no multiplier bits remain, else add or skip
//   ADD   | accumulate current shifted multiplicand
//   SHIFT | advance multiplicand left and multiplier right
//   DONE  | publish product, set sticky done
module mult_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  mult_shift_add_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 init_q;
  logic                 start;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [2*WIDTH-1:0]   result_r;
  logic                 done_r;

  // An init edge seen while busy is absorbed by init_q and lost, by design.
  assign start = bus.init & ~init_q;

  // Start-level history for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_q <= 1'b0;
    end else begin
      init_q <= bus.init;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (b_sh == '0) begin
          state_nxt = S_DONE;
        end else if (b_sh[0]) begin
          state_nxt = S_ADD;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_CHECK;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, accumulate, shift, and publish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          acc    <= '0;
          a_sh   <= {{WIDTH{1'b0}}, bus.op_A};
          b_sh   <= bus.op_B;
          done_r <= 1'b0;
        end
        S_ADD: begin
          // 2*WIDTH bits hold any WIDTH x WIDTH product, so no carry-out.
          acc <= acc + a_sh;
        end
        S_SHIFT: begin
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
        end
        S_DONE: begin
          result_r <= acc;
          done_r   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = result_r;
  assign bus.done   = done_r;
  assign bus.busy   = (state != S_IDLE);

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed bench for mult_shift_add: a table of operand pairs with hand-computed
// products and edge latencies, plus sequences for retrigger, mid-op init
// activity, init rising on the DONE edge, and reset during an operation.
module tb_mult_shift_add;

  localparam int WIDTH = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] prev_result;
  vec_t vecs[8];

  mult_shift_add_if #(.WIDTH(WIDTH)) bus ();

  mult_shift_add #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Produce a clean rising edge on init; returns after edge k (IDLE sees start).
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input string nm);
    @(negedge clk);
    bus.init = 1'b0;
    @(negedge clk);
    bus.op_A = a;
    bus.op_B = b;
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    check({nm, "_busy_load"}, {63'd0, bus.busy}, 64'd1);
  endtask

  // Counts edges after k until done. Optional init drop/rise (with operand
  // scramble) at given edge offsets; abort_at asserts reset at that offset.
  task automatic wait_done(input string nm, input int drop_at, input int rise_at,
                           input int abort_at, output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    lat = -1;
    for (int j = 1; j <= 70; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) begin
        check({nm, "_done_low_in_load"}, {63'd0, bus.done}, 64'd0);
        check({nm, "_result_held"}, {32'd0, bus.result}, {32'd0, prev_result});
      end
      if (bus.done) begin
        lat = j;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (j == drop_at) bus.init = 1'b0;
      if (j == rise_at) begin
        bus.init = 1'b1;
        bus.op_A = 16'h0001;
        bus.op_B = 16'h0001;
      end
      if (j == abort_at) begin
        reset = 1'b0;
        #1;
        lat = -2;
        break;
      end
    end
    if (lat == -1) $display("FAIL %s_timeout: no done within 70 edges", nm);
    check({nm, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
  endtask

  // Confirms the core stays idle (no hidden retrigger) for n edges.
  task automatic check_quiet(input string nm, input int n, input logic exp_done);
    bit ok;
    ok = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (bus.busy || (bus.done !== exp_done)) ok = 1'b0;
    end
    check({nm, "_quiet"}, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    int lat;
    pass_cnt    = 0;
    total_cnt   = 0;
    prev_result = 32'd0;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 11};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 51};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 3};
    vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000, 51};
    vecs[4] = '{16'h0007, 16'h0006, 32'h0000002A, 11};
    vecs[5] = '{16'h8000, 16'h8000, 32'h40000000, 36};
    vecs[6] = '{16'hABCD, 16'h0001, 32'h0000ABCD, 6};
    vecs[7] = '{16'h0002, 16'h0003, 32'h00000006, 9};

    reset    = 1'b0;
    bus.init = 1'b0;
    bus.op_A = '0;
    bus.op_B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", {32'd0, bus.result}, 64'd0);
    check("rst_done",   {63'd0, bus.done},   64'd0);
    check("rst_busy",   {63'd0, bus.busy},   64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      launch(vecs[i].a, vecs[i].b, nm);
      wait_done(nm, 2, 0, 0, lat);
      check({nm, "_latency"}, lat, vecs[i].lat);
      check({nm, "_result"}, {32'd0, bus.result}, {32'd0, vecs[i].prod});
      @(negedge clk);
      check({nm, "_idle_after"}, {63'd0, bus.busy}, 64'd0);
      prev_result = vecs[i].prod;
    end

    // Hold init high after completion: no retrigger, done stays set.
    launch(16'h0003, 16'h0005, "hold");
    wait_done("hold", 0, 0, 0, lat);
    check("hold_latency", lat, 11);
    prev_result = 32'h0000000F;
    check_quiet("hold", 12, 1'b1);
    launch(16'h0007, 16'h0006, "hold2");
    wait_done("hold2", 2, 0, 0, lat);
    check("hold2_result", {32'd0, bus.result}, 64'h2A);
    prev_result = 32'h0000002A;

    // Init toggled and operands changed mid-operation: ignored, no second op.
    launch(16'hFFFF, 16'hFFFF, "midtog");
    wait_done("midtog", 10, 12, 0, lat);
    check("midtog_latency", lat, 51);
    check("midtog_result", {32'd0, bus.result}, 64'hFFFE0001);
    prev_result = 32'hFFFE0001;
    check_quiet("midtog", 12, 1'b1);

    // Init rises so the edge lands on the DONE edge: completes, edge consumed.
    launch(16'h0003, 16'h0005, "simul");
    wait_done("simul", 2, 10, 0, lat);
    check("simul_latency", lat, 11);
    check("simul_result", {32'd0, bus.result}, 64'h0F);
    prev_result = 32'h0000000F;
    check_quiet("simul", 10, 1'b1);

    // Reset at edge 20 of FFFF x FFFF: immediate clear, then a fresh operation.
    launch(16'hFFFF, 16'hFFFF, "abort");
    wait_done("abort", 2, 0, 20, lat);
    check("abort_result", {32'd0, bus.result}, 64'd0);
    check("abort_done",   {63'd0, bus.done},   64'd0);
    check("abort_busy",   {63'd0, bus.busy},   64'd0);
    @(negedge clk);
    bus.init = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    prev_result = 32'd0;
    launch(16'h0002, 16'h0003, "post");
    wait_done("post", 2, 0, 0, lat);
    check("post_latency", lat, 9);
    check("post_result", {32'd0, bus.result}, 64'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
